// File: rtl/prime_pkg.sv
// Shared constants for the prime checker / collector pair.
package prime_pkg;

  localparam int NUM_W_DEF = 3;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  localparam logic PRIME     = 1'b1;
  localparam logic NOT_PRIME = 1'b0;

endpackage

// File: rtl/prime_fifo.sv
// Small FIFO holding prime numbers. Occupancy runs 0..DEPTH so that
// full and empty are unambiguous; pointers wrap naturally (DEPTH is 2^n).
// Reads are combinational from the head slot and return 0 when empty.
module prime_fifo
  import prime_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [NUM_W-1:0] wr_data,
  input  logic             pop,
  output logic [NUM_W-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [NUM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             push_ok;
  logic             pop_ok;

  // A clear cycle voids both handshakes.
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;

  assign empty   = (occ == '0);
  assign full    = (occ == FULL_OCC);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Storage; contents need no reset because empty masks the read port.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/prime_collector.sv
// Collects checker results: counts every accepted result and every prime,
// and queues only the primes for the downstream consumer.
module prime_collector
  import prime_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [NUM_W-1:0] in_number,
  input  logic             in_is_prime,
  output logic             in_ready,
  output logic             out_valid,
  output logic [NUM_W-1:0] out_number,
  input  logic             out_ready,
  output logic [CNT_W-1:0] prime_count,
  output logic [CNT_W-1:0] total_count,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic empty;
  logic accept;
  logic push;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready && !clear;
  assign push      = accept && (in_is_prime == PRIME);

  prime_fifo #(
    .NUM_W (NUM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .push    (push),
    .wr_data (in_number),
    .pop     (out_ready),
    .rd_data (out_number),
    .empty   (empty),
    .full    (full)
  );

  // Saturating result counters; saturation never throttles acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_count <= '0;
      prime_count <= '0;
    end else if (clear) begin
      total_count <= '0;
      prime_count <= '0;
    end else begin
      if (accept && total_count != CNT_MAX) total_count <= total_count + CNT_ONE;
      if (push && prime_count != CNT_MAX)   prime_count <= prime_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_prime_collector.sv
module tb_prime_collector;

  localparam int NUM_W = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic [NUM_W-1:0] in_number;
  logic             in_is_prime;
  logic             out_ready;

  logic             in_ready, out_valid, full;
  logic [NUM_W-1:0] out_number;
  logic [7:0]       prime_count, total_count;

  logic             s_in_ready, s_out_valid, s_full;
  logic [NUM_W-1:0] s_out_number;
  logic [2:0]       s_prime_count, s_total_count;

  int checks = 0;
  int failures = 0;

  logic [NUM_W-1:0] exp_q [$];
  int m_occ = 0;
  int m_total = 0;
  int m_prime = 0;
  bit mon_en = 0;
  int sat_pops = 0;

  always #5 clk = ~clk;

  prime_collector #(.NUM_W(NUM_W), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_number(in_number), .in_is_prime(in_is_prime),
    .in_ready(in_ready), .out_valid(out_valid), .out_number(out_number),
    .out_ready(out_ready), .prime_count(prime_count),
    .total_count(total_count), .full(full)
  );

  prime_collector #(.NUM_W(NUM_W), .DEPTH(DEPTH), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_number(in_number), .in_is_prime(in_is_prime),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_number(s_out_number),
    .out_ready(out_ready), .prime_count(s_prime_count),
    .total_count(s_total_count), .full(s_full)
  );

  function automatic logic is_p(int n);
    return (n == 2) || (n == 3) || (n == 5) || (n == 7);
  endfunction

  // Cycle model + scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic             acc, pop;
    logic [NUM_W-1:0] exp_num;
    if (!rst_n) begin
      m_occ = 0; m_total = 0; m_prime = 0;
      exp_q.delete();
    end else if (mon_en) begin
      checks++;
      if (in_ready !== (m_occ != DEPTH)) begin
        failures++; $display("FAIL mon_in_ready got=%0b want=%0b", in_ready, m_occ != DEPTH);
      end
      checks++;
      if (out_valid !== (m_occ != 0)) begin
        failures++; $display("FAIL mon_out_valid got=%0b want=%0b", out_valid, m_occ != 0);
      end
      checks++;
      if (full !== (m_occ == DEPTH)) begin
        failures++; $display("FAIL mon_full got=%0b want=%0b", full, m_occ == DEPTH);
      end
      checks++;
      if (total_count !== 8'(m_total) || prime_count !== 8'(m_prime)) begin
        failures++;
        $display("FAIL mon_counts got=%0d/%0d want=%0d/%0d", total_count, prime_count, m_total, m_prime);
      end
      if (m_occ == 0) begin
        checks++;
        if (out_number !== '0) begin
          failures++; $display("FAIL mon_out_number_empty got=%0d want=0", out_number);
        end
      end
      if (clear) begin
        m_occ = 0; m_total = 0; m_prime = 0;
        exp_q.delete();
      end else begin
        acc = in_valid && (m_occ != DEPTH);
        pop = (m_occ != 0) && out_ready;
        if (pop) begin
          exp_num = exp_q.pop_front();
          checks++;
          if (out_number !== exp_num) begin
            failures++; $display("FAIL sb_out_number got=%0d want=%0d", out_number, exp_num);
          end
          m_occ--;
        end
        if (acc) begin
          if (m_total != 255) m_total++;
          if (in_is_prime) begin
            if (m_prime != 255) m_prime++;
            exp_q.push_back(in_number);
            m_occ++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s_out_valid && out_ready && !clear) sat_pops++;
  end

  task automatic drive(input logic v, input int n, input logic p);
    @(posedge clk); #1;
    in_valid = v; in_number = NUM_W'(n); in_is_prime = p;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_number = '0;
    in_is_prime = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_number !== '0 || full !== 1'b0 ||
        prime_count !== 8'd0 || total_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_values got rdy=%0b vld=%0b num=%0d full=%0b pc=%0d tc=%0d want 1 0 0 0 0 0",
               in_ready, out_valid, out_number, full, prime_count, total_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_sweep();
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) drive(1'b1, n, is_p(n));
    idle(4);
    @(negedge clk);
    checks++;
    if (total_count !== 8'd8 || prime_count !== 8'd4) begin
      failures++;
      $display("FAIL sweep_counts got tc=%0d pc=%0d want tc=8 pc=4", total_count, prime_count);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    drive(1'b1, 2, 1'b1);
    drive(1'b1, 3, 1'b1);
    drive(1'b1, 5, 1'b1);
    drive(1'b1, 7, 1'b1);
    drive(1'b1, 3, 1'b1);
    @(negedge clk);
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL full_after_4 got full=%0b rdy=%0b want 1 0", full, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL full_pop_frees got rdy=%0b full=%0b want 1 0", in_ready, full);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (full !== 1'b1) begin
      failures++; $display("FAIL full_refill got full=%0b want 1", full);
    end
    out_ready = 1'b1;
    idle(6);
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{5, 7, 2, 3};
    out_ready = 1'b0;
    drive(1'b1, 2, 1'b1);
    drive(1'b1, 3, 1'b1);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_number = NUM_W'(vals[i % 4]); in_is_prime = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (dut.u_fifo.occ !== 3'd2) begin
        failures++; $display("FAIL b2b_occupancy iter=%0d got=%0d want=2", i, dut.u_fifo.occ);
      end
    end
    idle(5);
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    sat_pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, (i % 2) ? 7 : 5, 1'b1);
    idle(4);
    @(negedge clk);
    checks++;
    if (s_prime_count !== 3'd7 || s_total_count !== 3'd7) begin
      failures++;
      $display("FAIL sat_counts got pc=%0d tc=%0d want 7 7", s_prime_count, s_total_count);
    end
    checks++;
    if (prime_count !== 8'd10 || total_count !== 8'd10) begin
      failures++;
      $display("FAIL sat_wide_counts got pc=%0d tc=%0d want 10 10", prime_count, total_count);
    end
    checks++;
    if (sat_pops !== 10) begin
      failures++; $display("FAIL sat_outputs got=%0d want=10", sat_pops);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    drive(1'b1, 2, 1'b1);
    drive(1'b1, 3, 1'b1);
    drive(1'b1, 5, 1'b1);
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_number = 3'd7; in_is_prime = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || prime_count !== 8'd0 || total_count !== 8'd0) begin
      failures++;
      $display("FAIL clear_state got vld=%0b pc=%0d tc=%0d want 0 0 0", out_valid, prime_count, total_count);
    end
    idle(2);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL clear_drop got vld=%0b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 2, 1'b1);
    drive(1'b1, 3, 1'b1);
    drive(1'b1, 5, 1'b1);
    drive(1'b1, 7, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || full !== 1'b0 || in_ready !== 1'b1 || out_number !== '0 ||
        prime_count !== 8'd0 || total_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset got vld=%0b full=%0b rdy=%0b num=%0d pc=%0d tc=%0d want 0 0 1 0 0 0",
               out_valid, full, in_ready, out_number, prime_count, total_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3, 1'b1);
    drive(1'b1, 4, 1'b0);
    drive(1'b1, 5, 1'b1);
    idle(4);
    @(negedge clk);
    checks++;
    if (total_count !== 8'd3 || prime_count !== 8'd2) begin
      failures++;
      $display("FAIL resume_counts got tc=%0d pc=%0d want 3 2", total_count, prime_count);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_full();
    test_back_to_back();
    test_saturation();
    test_clear();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drained got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prime_collector.md
Name: prime_collector

Overview:
- Downstream consumer of the prime checker. Accepts a stream of (number, is_prime) results under valid/ready.
- Keeps saturating counts of all results and of primes.
- Buffers prime numbers only in a small FIFO, which drains to a valid/ready output port for the next stage (display or logger).
- Non-primes are counted and discarded.

Parameters:
- NUM_W, 3, width of number field (matches checker input width)
- DEPTH, 4, FIFO entries (power of 2, >= 2)
- CNT_W, 8, width of prime/total counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous clear of FIFO and counters
- in_valid  input  1  result present
- in_number  input  NUM_W  number that was checked
- in_is_prime  input  1  1 = prime, 0 = not prime
- in_ready  output  1  collector can accept a result this cycle
- out_valid  output  1  FIFO head holds a prime
- out_number  output  NUM_W  prime at FIFO head
- out_ready  input  1  downstream takes head this cycle
- prime_count  output  CNT_W  primes accepted since reset/clear
- total_count  output  CNT_W  results accepted since reset/clear
- full  output  1  FIFO holds DEPTH entries

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n); all state clears on rst_n low regardless of clk.
- Reset values: in_ready=1, out_valid=0, out_number=0, prime_count=0, total_count=0, full=0, pointers=0, occupancy=0.
- Handshakes:
  - in_ready = !full (combinational from occupancy).
  - Accept when in_valid && in_ready. Only accepted results are counted.
  - Pop when out_valid && out_ready.
- Push rule: an accepted result with in_is_prime=1 writes in_number at the write pointer. An accepted non-prime increments total_count only.
- Latency: a pushed prime appears on out_valid/out_number the cycle after acceptance. There is no same-cycle bypass, even when the FIFO is empty.
- out_valid = (occupancy != 0). out_number = mem[rd_ptr] when out_valid, else 0.
- While out_valid && !out_ready, out_number and out_valid hold stable.
- Occupancy is 0..DEPTH (width clog2(DEPTH)+1). Pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Simultaneous push and pop (non-full, non-empty): occupancy unchanged, both pointers advance.
- Full: in_ready=0 for every input, prime or not. The upstream must hold in_valid/in_number/in_is_prime stable until accepted. A pop while full frees a slot; in_ready rises the next cycle.
- Counters:
  - total_count +1 per accepted result; prime_count +1 per accepted prime.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Saturation does not block acceptance or FIFO push.
- clear (synchronous, highest priority after reset):
  - Resets pointers, occupancy and counters to 0 at the next edge.
  - Any push or pop presented in that cycle is ignored.
  - in_ready is still driven as !full that cycle, but the handshake is void. Upstream must treat a transfer in a clear cycle as dropped.
- Reset mid-operation: FIFO content is lost. Outputs go to reset values immediately (asynchronously).
- in_number values 0 and 1 with in_is_prime=1 are stored as given. The collector does not re-check primality.

Decomposition:
- Package prime_pkg: NUM_W/DEPTH/CNT_W default constants, and localparams PRIME=1'b1 and NOT_PRIME=1'b0, shared with the checker.
- Sub-module prime_fifo: DEPTH x NUM_W storage, pointers, occupancy, full/empty, and a synchronous clear input.
- prime_collector contains the accept logic, the push qualification (is_prime) and the saturating counters.

Test Plan:
- Reset then sweep 0..7 back-to-back with correct is_prime, out_ready=1 -> out_number sequence 2,3,5,7, each one cycle after its input; total_count=8, prime_count=4.
- out_ready=0, push primes 2,3,5,7,3 -> full=1 after 4th accept; in_ready=0 and 5th held. Release out_ready one cycle -> 2 popped, 3 then accepted next cycle; FIFO order 3,5,7,3.
- FIFO at 2 entries, simultaneous accept of prime 5 and pop -> occupancy stays 2; pointers wrap correctly across 3 full wrap cycles with no lost or duplicated data.
- CNT_W=3, feed 10 primes with out_ready=1 -> prime_count and total_count stick at 7; all 10 primes appear on output.
- clear asserted with 3 entries and in_valid prime present -> next cycle out_valid=0, counts=0; that input is not stored.
- rst_n pulsed low mid-stream between clock edges -> out_valid, full and counts go to 0 without waiting for clk; resuming after reset works from empty.
